// File: rtl/csr_file_m_if.sv
// csr_file_m_if: request/response channel between the pipeline and the CSR file
interface csr_file_m_if #(parameter int XLEN = 32) ();
    logic            req_valid;
    logic            req_ready;
    logic [11:0]     csr_addr;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [4:0]      rs1_addr_uimm;
    logic [4:0]      req_rd_addr;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rd_data;
    logic [4:0]      rsp_rd_addr;
    logic            rsp_illegal;
    modport master (
        output req_valid, csr_addr, funct3, rs1_data, rs1_addr_uimm, req_rd_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_rd_data, rsp_rd_addr, rsp_illegal
    );
    modport slave (
        input  req_valid, csr_addr, funct3, rs1_data, rs1_addr_uimm, req_rd_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_rd_data, rsp_rd_addr, rsp_illegal
    );
endinterface

// File: rtl/csr_file_m.sv
// csr_file_m: machine-mode Zicsr CSR file with 64-bit counters and a registered response channel
module csr_file_m #(
    parameter int          XLEN     = 32,
    parameter int          HARTID   = 0,
    parameter logic [25:0] MISA_EXT = 26'h0000100
) (
    input logic         clk,
    input logic         rst_n,
    input logic         instret,
    csr_file_m_if.slave bus
);
    localparam logic [XLEN-1:0] MSTATUS_FIX = XLEN'(32'h1800);
    localparam logic [XLEN-1:0] MSTATUS_W   = XLEN'(32'h88);
    localparam logic [XLEN-1:0] MIE_W       = XLEN'(32'h888);
    logic [XLEN-1:0] mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, misa, operand, old, wdata;
    logic [63:0]     mcycle, minstret, mcycle_n, minstret_n;
    logic            accept, wen, hit, illegal, wr;
    assign bus.req_ready = !bus.rsp_valid || bus.rsp_ready;
    assign accept  = bus.req_valid && bus.req_ready;
    assign operand = bus.funct3[2] ? XLEN'(bus.rs1_addr_uimm) : bus.rs1_data;
    assign wen     = bus.funct3[1:0] == 2'b01 || bus.rs1_addr_uimm != 5'd0;
    assign illegal = !hit || bus.funct3[1:0] == 2'b00 || (wen && bus.csr_addr[11:10] == 2'b11);
    assign wr      = accept && wen && !illegal;
    assign wdata   = bus.funct3[1:0] == 2'b01 ? operand :
                     bus.funct3[1:0] == 2'b10 ? old | operand : old & ~operand;
    always_comb begin
        misa = '0;
        misa[XLEN-1:XLEN-2] = XLEN == 32 ? 2'd1 : 2'd2;
        misa[25:0] = MISA_EXT;
    end
    always_comb begin
        hit = 1'b1;
        old = '0;
        case (bus.csr_addr)
            12'hF11, 12'hF12, 12'hF13, 12'hF15: old = '0;
            12'hF14:          old = XLEN'(HARTID);
            12'h301:          old = misa;
            12'h300:          old = mstatus | MSTATUS_FIX;
            12'h304:          old = mie;
            12'h305:          old = mtvec;
            12'h340:          old = mscratch;
            12'h341:          old = mepc;
            12'h342:          old = mcause;
            12'h343:          old = mtval;
            12'hB00, 12'hC00: old = mcycle[XLEN-1:0];
            12'hB02, 12'hC02: old = minstret[XLEN-1:0];
            12'hB80, 12'hC80: begin hit = XLEN == 32; old = XLEN'(mcycle[63:32]); end
            12'hB82, 12'hC82: begin hit = XLEN == 32; old = XLEN'(minstret[63:32]); end
            default:          hit = 1'b0;
        endcase
    end
    // a counter write replaces the increment for that cycle
    always_comb begin
        mcycle_n   = mcycle + 64'd1;
        minstret_n = minstret + 64'(instret);
        if (wr && bus.csr_addr == 12'hB00) begin
            mcycle_n = mcycle;
            mcycle_n[XLEN-1:0] = wdata;
        end
        if (wr && bus.csr_addr == 12'hB02) begin
            minstret_n = minstret;
            minstret_n[XLEN-1:0] = wdata;
        end
        if (wr && bus.csr_addr == 12'hB80) mcycle_n = {wdata[31:0], mcycle[31:0]};
        if (wr && bus.csr_addr == 12'hB82) minstret_n = {wdata[31:0], minstret[31:0]};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus         <= '0;
            mie             <= '0;
            mtvec           <= '0;
            mscratch        <= '0;
            mepc            <= '0;
            mcause          <= '0;
            mtval           <= '0;
            mcycle          <= '0;
            minstret        <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rd_data <= '0;
            bus.rsp_rd_addr <= '0;
            bus.rsp_illegal <= 1'b0;
        end else begin
            mcycle   <= mcycle_n;
            minstret <= minstret_n;
            if (wr) begin
                case (bus.csr_addr)
                    12'h300: mstatus  <= wdata & MSTATUS_W;
                    12'h304: mie      <= wdata & MIE_W;
                    12'h305: mtvec    <= {wdata[XLEN-1:2], 1'b0, wdata[0]};
                    12'h340: mscratch <= wdata;
                    12'h341: mepc     <= {wdata[XLEN-1:2], 2'b00};
                    12'h342: mcause   <= wdata;
                    12'h343: mtval    <= wdata;
                    default: ;
                endcase
            end
            if (accept) begin
                bus.rsp_valid   <= 1'b1;
                bus.rsp_rd_data <= illegal ? '0 : old;
                bus.rsp_rd_addr <= bus.req_rd_addr;
                bus.rsp_illegal <= illegal;
            end else if (bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_csr_file_m.sv
// tb_csr_file_m: randomized scoreboard bench with a spec-level CSR reference model
module tb_csr_file_m;
    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  rd;
        logic        ill;
    } rsp_t;
    logic clk = 0, rst_n = 0, instret = 0, instret64 = 0;
    int checks = 0, errors = 0;
    rsp_t sbq[$];
    logic [31:0] regs  [int];
    logic [31:0] wmask [int];
    logic [63:0] mcyc, mins;
    logic m_valid;
    logic [11:0] alist [0:23] = '{12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'hF15, 12'h301, 12'h300, 12'h304,
                                  12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'hB00, 12'hB02, 12'hB80,
                                  12'hB82, 12'hC00, 12'hC02, 12'hC80, 12'hC82, 12'h306, 12'h7C0, 12'hB01};
    csr_file_m_if #(.XLEN(32)) ifc ();
    csr_file_m_if #(.XLEN(64)) if64 ();
    csr_file_m #(.XLEN(32), .HARTID(7)) dut (.clk(clk), .rst_n(rst_n), .instret(instret), .bus(ifc.slave));
    csr_file_m #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .instret(instret64), .bus(if64.slave));
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask
    task automatic mreset();
        regs.delete();
        wmask.delete();
        foreach (alist[i]) if (alist[i][11:8] == 4'hF || alist[i][11:8] == 4'h3) begin
            regs[alist[i]] = 32'h0;
            wmask[alist[i]] = 32'hFFFF_FFFF;
        end
        regs.delete(12'h306);
        wmask.delete(12'h306);
        regs[12'hF14] = 32'd7;
        regs[12'h301] = 32'h4000_0100;
        regs[12'h300] = 32'h0000_1800;
        foreach (regs[a]) if (a[11:8] == 4'hF || a == 12'h301) wmask[a] = 32'h0;
        wmask[12'h300] = 32'h88;
        wmask[12'h304] = 32'h888;
        wmask[12'h305] = ~32'h2;
        wmask[12'h341] = ~32'h3;
        mcyc = 0;
        mins = 0;
        m_valid = 0;
        sbq.delete();
    endtask
    function automatic bit known(input logic [11:0] a);
        return regs.exists(a) || a inside {12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC02, 12'hC80, 12'hC82};
    endfunction
    function automatic logic [31:0] mread(input logic [11:0] a);
        logic [63:0] c = a[1] ? mins : mcyc;
        if (regs.exists(a)) return regs[a];
        return a[7] ? c[63:32] : c[31:0];
    endfunction
    task automatic model_step(input logic acc, input logic [11:0] a, input logic [2:0] f3, input logic [31:0] d,
                              input logic [4:0] u, input logic [4:0] rd, input logic rr, input logic ir);
        logic wen, ill, wc, wi;
        logic [31:0] old, op, nv;
        wc = 0;
        wi = 0;
        if (acc) begin
            wen = f3[1:0] == 2'b01 || u != 0;
            ill = !known(a) || f3[1:0] == 2'b00 || (wen && a[11:10] == 2'b11);
            old = ill ? 32'h0 : mread(a);
            sbq.push_back('{d: old, rd: rd, ill: ill});
            if (!ill && wen) begin
                op = f3[2] ? {27'h0, u} : d;
                nv = f3[1:0] == 2'b01 ? op : f3[1:0] == 2'b10 ? (old | op) : (old & ~op);
                if (regs.exists(a)) regs[a] = (nv & wmask[a]) | (regs[a] & ~wmask[a]);
                else if (a[1]) begin mins = a[7] ? {nv, mins[31:0]} : {mins[63:32], nv}; wi = 1; end
                else begin mcyc = a[7] ? {nv, mcyc[31:0]} : {mcyc[63:32], nv}; wc = 1; end
            end
        end
        if (!wc) mcyc = mcyc + 1;
        if (!wi && ir) mins = mins + 1;
        m_valid = acc ? 1'b1 : (rr ? 1'b0 : m_valid);
    endtask
    // starts and ends on a falling edge
    task automatic cycle(input logic v, input logic [11:0] a, input logic [2:0] f3, input logic [31:0] d,
                         input logic [4:0] u, input logic [4:0] rd, input logic rr, input logic ir);
        logic er;
        ifc.req_valid = v;
        ifc.csr_addr = a;
        ifc.funct3 = f3;
        ifc.rs1_data = d;
        ifc.rs1_addr_uimm = u;
        ifc.req_rd_addr = rd;
        ifc.rsp_ready = rr;
        instret = ir;
        #1;
        er = !m_valid || rr;
        chk("req_ready", ifc.req_ready, er);
        chk("rsp_valid", ifc.rsp_valid, m_valid);
        @(posedge clk);
        model_step(v && er, a, f3, d, u, rd, rr, ir);
        @(negedge clk);
    endtask
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && ifc.rsp_valid) begin
                if (sbq.size() == 0) chk("rsp_unexpected", 1, 0);
                else begin
                    e = sbq[0];
                    chk("rsp_rd_data", ifc.rsp_rd_data, e.d);
                    chk("rsp_rd_addr", ifc.rsp_rd_addr, e.rd);
                    chk("rsp_illegal", ifc.rsp_illegal, e.ill);
                    if (ifc.rsp_ready) void'(sbq.pop_front());
                end
            end
        end
    end
    initial begin
        if64.req_valid = 0;
        if64.csr_addr = 0;
        if64.funct3 = 0;
        if64.rs1_data = 0;
        if64.rs1_addr_uimm = 0;
        if64.req_rd_addr = 0;
        if64.rsp_ready = 1;
        wait (rst_n);
        @(negedge clk);
        if64.req_valid = 1;
        if64.csr_addr = 12'hB80;
        if64.funct3 = 3'b010;
        if64.req_rd_addr = 5'd3;
        @(negedge clk);
        chk("x64_b80_illegal", if64.rsp_illegal, 1);
        chk("x64_b80_data", if64.rsp_rd_data, 0);
        if64.csr_addr = 12'h340;
        if64.funct3 = 3'b001;
        if64.rs1_data = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        chk("x64_wr_illegal", if64.rsp_illegal, 0);
        if64.funct3 = 3'b010;
        @(negedge clk);
        chk("x64_mscratch", if64.rsp_rd_data, 64'h0123_4567_89AB_CDEF);
        chk("x64_misa_rdaddr", if64.rsp_rd_addr, 3);
        if64.req_valid = 0;
    end
    initial begin
        mreset();
        ifc.req_valid = 0;
        ifc.rsp_ready = 1;
        #1;
        chk("reset_rsp_valid", ifc.rsp_valid, 0);
        chk("reset_rd_data", ifc.rsp_rd_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        cycle(1, 12'h340, 3'b001, 32'hDEADBEEF, 5'd1, 5'd5, 1, 0);
        cycle(1, 12'h340, 3'b010, 32'h12345678, 5'd0, 5'd6, 1, 0);
        cycle(1, 12'h300, 3'b110, 32'h0, 5'd8, 5'd1, 1, 0);
        cycle(1, 12'h300, 3'b111, 32'h0, 5'd8, 5'd2, 1, 0);
        cycle(1, 12'h300, 3'b010, 32'h0, 5'd0, 5'd3, 1, 0);
        cycle(1, 12'hB00, 3'b001, 32'hFFFFFFFF, 5'd1, 5'd4, 1, 0);
        cycle(0, 12'h0, 3'b000, 32'h0, 5'd0, 5'd0, 1, 0);
        cycle(1, 12'hB80, 3'b010, 32'h0, 5'd0, 5'd7, 1, 0);
        repeat (10) cycle(0, 12'h0, 3'b000, 32'h0, 5'd0, 5'd0, 1, 1);
        cycle(1, 12'hC02, 3'b010, 32'h0, 5'd0, 5'd8, 1, 0);
        cycle(1, 12'hC00, 3'b001, 32'h55, 5'd3, 5'd9, 1, 0);
        cycle(1, 12'hC00, 3'b010, 32'h55, 5'd0, 5'd10, 1, 0);
        cycle(1, 12'h301, 3'b001, 32'hFFFFFFFF, 5'd1, 5'd11, 1, 0);
        cycle(1, 12'hF14, 3'b010, 32'h0, 5'd0, 5'd12, 1, 0);
        cycle(1, 12'h340, 3'b001, 32'h1, 5'd1, 5'd13, 1, 0);
        repeat (3) cycle(1, 12'h340, 3'b001, 32'h2, 5'd1, 5'd14, 0, 0);
        cycle(1, 12'h340, 3'b010, 32'h0, 5'd0, 5'd15, 1, 0);
        cycle(0, 12'h0, 3'b000, 32'h0, 5'd0, 5'd0, 1, 0);
        cycle(1, 12'h340, 3'b001, 32'h5555AAAA, 5'd1, 5'd9, 0, 0);
        ifc.req_valid = 0;
        ifc.rsp_ready = 0;
        #3;
        rst_n = 0;
        #1;
        chk("async_rsp_valid", ifc.rsp_valid, 0);
        chk("async_rd_data", ifc.rsp_rd_data, 0);
        chk("async_rd_addr", ifc.rsp_rd_addr, 0);
        chk("async_illegal", ifc.rsp_illegal, 0);
        mreset();
        @(negedge clk);
        rst_n = 1;
        cycle(1, 12'h340, 3'b010, 32'h0, 5'd0, 5'd16, 1, 0);
        for (int i = 0; i < 1500; i++)
            cycle($urandom_range(0, 3) != 0, alist[$urandom_range(0, 23)], 3'($urandom), $urandom,
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), 5'($urandom),
                  $urandom_range(0, 3) != 0, 1'($urandom));
        repeat (3) cycle(0, 12'h0, 3'b000, 32'h0, 5'd0, 5'd0, 1, 0);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/csr_file_m.md
Name: csr_file_m

Overview:
Parametrised machine-mode CSR file for the RV32I/RV64I core, sitting between decode/execute and the GPR writeback port.
- Executes all six Zicsr instructions with correct read/write suppression and WARL masking.
- Implements 64-bit mcycle/minstret with RV32 high-half aliases.
- Flags illegal accesses.
- Returns results through a registered valid/ready response channel.

Parameters:
XLEN, 32, register width; legal values 32 or 64.
HARTID, 0, constant returned by mhartid.
MISA_EXT, 26'h0000100, misa extension bits [25:0]; default is I only.

Ports:
i_clk  in  1  clock
i_nrst  in  1  asynchronous active-low reset
i_req_valid  in  1  CSR request present
o_req_ready  out  1  request accepted when i_req_valid && o_req_ready
i_csr_addr  in  12  CSR address
i_funct3  in  3  Zicsr funct3
i_rs1_data  in  XLEN  rs1 value for register forms
i_rs1_addr_uimm  in  5  rs1 index, or uimm for immediate forms
i_rd_addr  in  5  destination GPR
i_instret  in  1  one-cycle pulse per retired instruction
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  response consumed
o_rd_data  out  XLEN  old CSR value for the GPR
o_rd_addr  out  5  destination GPR index; 0 means no writeback
o_illegal  out  1  illegal-instruction flag for this response

Behaviour:
- Reset (asynchronous, i_nrst=0):
  - o_rsp_valid=0, o_rd_data=0, o_rd_addr=0, o_illegal=0.
  - All writable CSRs and counters cleared.
  - Any pending response is dropped.
  - o_req_ready=1 from the first clock edge after reset release.
- Handshake:
  - o_req_ready = !o_rsp_valid || i_rsp_ready.
  - An accepted request produces o_rsp_valid on the next cycle.
  - Response outputs are held stable while o_rsp_valid && !i_rsp_ready.
  - Back-to-back requests give one response per cycle.
- Operand: register forms use i_rs1_data; immediate forms zero-extend i_rs1_addr_uimm to XLEN.
- Write enable:
  - CSRRW/CSRRWI always write.
  - CSRRS/CSRRC/CSRRSI/CSRRCI write only when i_rs1_addr_uimm != 0.
  - New value for RW forms = operand; S forms = old | operand; C forms = old & ~operand.
- Read value: o_rd_data = CSR value sampled at the accept edge, before that cycle's write or increment. o_rd_addr = i_rd_addr.
- Implemented CSRs:
  - Read-only: mvendorid F11=0, marchid F12=0, mimpid F13=0, mhartid F14=HARTID, mconfigptr F15=0.
  - misa 301: read-only; MXL = 1 for XLEN=32, 2 for XLEN=64, in the top 2 bits; MISA_EXT in [25:0]; writes ignored, not illegal.
  - mstatus 300: MIE[3] and MPIE[7] writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - mie 304: writable bits 3, 7, 11 only.
  - mtvec 305: bit[1] forced 0; bit[0] (mode) writable.
  - mscratch 340, mcause 342, mtval 343: full width.
  - mepc 341: bits[1:0] forced 0.
  - mcycle B00, minstret B02: read/write.
  - cycle C00, instret C02: read-only shadows of mcycle and minstret.
  - XLEN=32 only: mcycleh B80, minstreth B82 (read/write), cycleh C80, instreth C82 (read-only shadows).
- Counters:
  - 64-bit; mcycle increments every cycle, minstret on i_instret.
  - Both wrap from all-ones to 0.
  - Writing the low half replaces [XLEN-1:0]; writing the high half replaces [63:32].
  - A CSR write beats the increment in the same cycle; no increment occurs that cycle.
- Illegal conditions, all with no state change, o_rd_data=0, o_illegal=1:
  - unimplemented address;
  - funct3 000 or 100;
  - a write enabled to address[11:10]==2'b11;
  - a high-half address when XLEN=64.
- Reads never have side effects.

Test Plan:
- Reset, then CSRRW mscratch with rs1_data=32'hDEADBEEF, rd=5 -> rsp: rd_data=0, rd_addr=5; next CSRRS mscratch with rs1=x0 -> rd_data=32'hDEADBEEF.
- CSRRSI mstatus uimm=8, then CSRRCI uimm=8 -> second read returns 32'h1808; third read returns 32'h1800.
- XLEN=32: CSRRW mcycle with 32'hFFFFFFFF, then read mcycleh after carry -> 1; with i_instret held high for 10 cycles, instret reads 10.
- CSRRW cycle C00 -> o_illegal=1, rd_data=0, mcycle unaffected; CSRRS C00 with rs1=x0 -> legal, returns count.
- Hold i_rsp_ready=0 for 3 cycles with back-to-back requests -> o_req_ready=0, response stable, no request lost; XLEN=64 access to B80 -> illegal.
- Assert i_nrst low while o_rsp_valid=1 -> outputs 0 immediately (asynchronously), response dropped, mscratch reads 0.
